// File: rtl/qnigma_dns_resolver_pkg.sv
// Shared types and constants for the DNS (AAAA) resolver and its answer cache.
package qnigma_dns_resolver_pkg;

  localparam int HOST_BYTES = 16;
  localparam int MAX_DNS_SRV = 4;

  localparam int UDP_HEADER_LEN = 8;
  localparam int DNS_HEADER_LEN = 12;
  localparam int DNS_QUERY_INFO_LEN = 4;

  typedef logic [127:0] ip_t;

  typedef struct packed {
    logic [7:0]              lng;
    logic [HOST_BYTES*8-1:0] str;
  } hostname_t;

  typedef enum logic [0:0] {REF_IP_LL, REF_IP_GLB} ref_ip_t;

  typedef struct packed {
    ip_t         rem;
    ref_ip_t     loc_ref;
    logic [7:0]  pro;
    logic [7:0]  hop;
    logic [15:0] lng;
  } meta_ip_t;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] lng;
  } meta_udp_t;

  typedef struct packed {
    hostname_t   hst;
    ip_t         addr;
    logic [31:0] ttl;
    logic [15:0] tid;
    logic [15:0] flg;
    logic [15:0] num;
    logic [15:0] ans;
    logic [15:0] aut;
    logic [15:0] add;
    logic [15:0] typ;
    logic [15:0] cls;
  } meta_dns_t;

  localparam logic [15:0] DNS_SERVER_PORT        = 16'd53;
  localparam logic [15:0] DNS_DEFAULT_LOCAL_PORT = 16'd53535;
  localparam logic [15:0] DNS_FLAGS_QUERY        = 16'h0100;
  localparam logic [15:0] DNS_TYPE_AAAA          = 16'd28;
  localparam logic [15:0] DNS_CLASS_IN           = 16'd1;
  localparam logic [7:0]  DNS_HOP_LIMIT          = 8'd64;
  localparam logic [7:0]  IP_PROTO_UDP           = 8'd17;
  localparam ip_t DNS_IP_ADDR_PRI = 128'h2001_4860_4860_0000_0000_0000_0000_8888;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_REQUEST, ST_RESPOND, ST_NEXT_SERV
  } state_t;

  function automatic logic [31:0] ttl_clip(input logic [31:0] ttl, input logic [31:0] cap);
    return (ttl > cap) ? cap : ttl;
  endfunction

endpackage

// File: rtl/qnigma_dns_resolver_cache.sv
// Hostname->address answer cache: one compare port walked by index, TTL aging in
// seconds, first-free / round-robin replacement and a global flush.
module qnigma_dns_resolver_cache
  import qnigma_dns_resolver_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          tick_s_i,
  input  logic          flush_i,
  input  logic [IW-1:0] lkp_idx_i,
  input  hostname_t     lkp_host_i,
  output logic          lkp_hit_o,
  output ip_t           lkp_ip_o,
  input  logic          wr_i,
  input  hostname_t     wr_host_i,
  input  ip_t           wr_ip_i,
  input  logic [31:0]   wr_ttl_i
);

  logic [DEPTH-1:0] vld_q;
  hostname_t        host_q [DEPTH];
  ip_t              ip_q   [DEPTH];
  logic [31:0]      ttl_q  [DEPTH];
  logic [IW-1:0]    vic_q;
  logic [IW-1:0]    wr_sel;
  logic             wr_free;
  logic             expiring;

  always_comb begin
    wr_sel  = vic_q;
    wr_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!wr_free && !vld_q[i]) begin
        wr_sel  = IW'(i);
        wr_free = 1'b1;
      end
    end
  end

  // An entry that ages out this very cycle, or any flush, forces a miss.
  assign expiring  = tick_s_i && (ttl_q[lkp_idx_i] == 32'd1);
  assign lkp_hit_o = vld_q[lkp_idx_i] && (host_q[lkp_idx_i] == lkp_host_i) &&
                     !expiring && !flush_i;
  assign lkp_ip_o  = ip_q[lkp_idx_i];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (tick_s_i && vld_q[i]) ttl_q[i] <= ttl_q[i] - 32'd1;
    end
    if (wr_i) begin
      host_q[wr_sel] <= wr_host_i;
      ip_q[wr_sel]   <= wr_ip_i;
      ttl_q[wr_sel]  <= wr_ttl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      vic_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tick_s_i && vld_q[i] && (ttl_q[i] == 32'd1)) vld_q[i] <= 1'b0;
      end
      if (wr_i) begin
        vld_q[wr_sel] <= 1'b1;
        if (!wr_free) vic_q <= (vic_q == IW'(DEPTH-1)) ? '0 : vic_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/qnigma_dns_resolver.sv
// AAAA resolver: cache lookup, query issue with per-try timeout and retries,
// transaction-ID matching and RDNSS server rotation.
//
// state      | meaning
// IDLE       | waiting for req; hostname latched on accept
// LOOKUP     | compare one cache entry per cycle
// REQUEST    | bump tid/try, arm timer, raise tx_pend
// RESPOND    | wait for matching reply or timeout
// NEXT_SERV  | rotate server slot, report failure, solicit RA
module qnigma_dns_resolver
  import qnigma_dns_resolver_pkg::*;
#(
  parameter int CACHE_DEPTH = 4,
  parameter int TIMEOUT_MS  = 1000,
  parameter int TRIES       = 3,
  parameter int MAX_SRV     = MAX_DNS_SRV,
  parameter int TTL_CAP_S   = 3600,
  parameter int BASE_TID    = 12345
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_ms_i,
  input  logic       tick_s_i,
  input  logic       dns_avl_i,
  input  ip_t        dns_ip_i,
  output logic [7:0] dns_idx_o,
  input  hostname_t  hostname_i,
  input  logic       req_i,
  input  logic       flush_i,
  output logic       acc_o,
  output logic       val_o,
  output logic       err_o,
  output logic       hit_o,
  output ip_t        addr_o,
  input  logic       rcv_i,
  input  meta_udp_t  rx_meta_udp_i,
  input  meta_dns_t  rx_meta_dns_i,
  output meta_ip_t   tx_meta_ip_o,
  output meta_udp_t  tx_meta_udp_o,
  output meta_dns_t  tx_meta_dns_o,
  output logic       tx_pend_o,
  input  logic       tx_acpt_i,
  input  logic       tx_done_i,
  output logic       rs_send_o
);

  localparam int IW  = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam int TW  = $clog2(TIMEOUT_MS + 1);
  localparam int TRW = $clog2(TRIES + 1);

  state_t         state_q;
  logic [IW-1:0]  idx_q;
  logic [TW-1:0]  tmr_q;
  logic [TRW-1:0] try_q;
  logic [15:0]    tid_q;
  logic [7:0]     dns_idx_q;
  hostname_t      host_q;
  ip_t            addr_q;
  logic           acc_q, val_q, err_q, hit_q, rs_send_q, tx_pend_q;
  meta_ip_t       tx_ip_q;
  meta_udp_t      tx_udp_q;
  meta_dns_t      tx_dns_q;
  logic           wr_q;
  ip_t            wr_ip_q;
  logic [31:0]    wr_ttl_q;

  logic           c_hit;
  ip_t            c_ip;
  logic           rx_ok;
  logic [15:0]    qry_lng;
  logic           unused_ok;

  qnigma_dns_resolver_cache #(.DEPTH(CACHE_DEPTH), .IW(IW)) u_cache (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .tick_s_i   (tick_s_i),
    .flush_i    (flush_i),
    .lkp_idx_i  (idx_q),
    .lkp_host_i (host_q),
    .lkp_hit_o  (c_hit),
    .lkp_ip_o   (c_ip),
    .wr_i       (wr_q),
    .wr_host_i  (host_q),
    .wr_ip_i    (wr_ip_q),
    .wr_ttl_i   (wr_ttl_q)
  );

  assign rx_ok = rcv_i && (rx_meta_udp_i.src == DNS_SERVER_PORT) &&
                 (rx_meta_udp_i.dst == DNS_DEFAULT_LOCAL_PORT) &&
                 (rx_meta_dns_i.tid == tid_q) && rx_meta_dns_i.flg[15];

  assign qry_lng = 16'(UDP_HEADER_LEN + DNS_HEADER_LEN + DNS_QUERY_INFO_LEN + 1) +
                   {8'd0, host_q.lng};

  // Receive fields the resolver has no use for.
  assign unused_ok = ^{rx_meta_udp_i.lng, rx_meta_dns_i.hst, rx_meta_dns_i.flg[14:4],
                       rx_meta_dns_i.num, rx_meta_dns_i.aut, rx_meta_dns_i.add,
                       rx_meta_dns_i.typ, rx_meta_dns_i.cls};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      try_q     <= '0;
      tid_q     <= 16'(BASE_TID);
      dns_idx_q <= '0;
      host_q    <= '0;
      addr_q    <= '0;
      acc_q     <= 1'b0;
      val_q     <= 1'b0;
      err_q     <= 1'b0;
      hit_q     <= 1'b0;
      rs_send_q <= 1'b0;
      tx_pend_q <= 1'b0;
      tx_ip_q   <= '0;
      tx_udp_q  <= '0;
      tx_dns_q  <= '0;
      wr_q      <= 1'b0;
      wr_ip_q   <= '0;
      wr_ttl_q  <= '0;
    end else begin
      acc_q     <= 1'b0;
      val_q     <= 1'b0;
      err_q     <= 1'b0;
      hit_q     <= 1'b0;
      rs_send_q <= 1'b0;
      wr_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            host_q  <= hostname_i;
            acc_q   <= 1'b1;
            idx_q   <= '0;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (c_hit) begin
            addr_q  <= c_ip;
            val_q   <= 1'b1;
            hit_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (idx_q == IW'(CACHE_DEPTH-1)) begin
            try_q   <= '0;
            state_q <= ST_REQUEST;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_REQUEST: begin
          tid_q     <= tid_q + 16'd1;
          tmr_q     <= TW'(TIMEOUT_MS);
          try_q     <= try_q + 1'b1;
          tx_pend_q <= 1'b1;
          tx_ip_q   <= '{rem: dns_avl_i ? dns_ip_i : DNS_IP_ADDR_PRI, loc_ref: REF_IP_GLB,
                         pro: IP_PROTO_UDP, hop: DNS_HOP_LIMIT, lng: qry_lng};
          tx_udp_q  <= '{src: DNS_DEFAULT_LOCAL_PORT, dst: DNS_SERVER_PORT, lng: qry_lng};
          tx_dns_q  <= '{hst: host_q, addr: '0, ttl: '0, tid: tid_q + 16'd1,
                         flg: DNS_FLAGS_QUERY, num: 16'd1, ans: 16'd0, aut: 16'd0,
                         add: 16'd0, typ: DNS_TYPE_AAAA, cls: DNS_CLASS_IN};
          state_q   <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (tx_acpt_i || tx_done_i) tx_pend_q <= 1'b0;
          if (tick_ms_i && (tmr_q != '0)) tmr_q <= tmr_q - 1'b1;
          // A matching reply beats a timeout landing in the same cycle.
          if (rx_ok) begin
            tx_pend_q <= 1'b0;
            state_q   <= ST_IDLE;
            if ((rx_meta_dns_i.flg[3:0] == 4'd0) && (rx_meta_dns_i.ans != 16'd0)) begin
              val_q    <= 1'b1;
              addr_q   <= rx_meta_dns_i.addr;
              wr_q     <= (rx_meta_dns_i.ttl != 32'd0);
              wr_ip_q  <= rx_meta_dns_i.addr;
              wr_ttl_q <= ttl_clip(rx_meta_dns_i.ttl, 32'(TTL_CAP_S));
            end else begin
              err_q <= 1'b1;
            end
          end else if (tmr_q == '0) begin
            tx_pend_q <= 1'b0;
            state_q   <= (try_q < TRW'(TRIES)) ? ST_REQUEST : ST_NEXT_SERV;
          end
        end
        ST_NEXT_SERV: begin
          dns_idx_q <= (dns_idx_q == 8'(MAX_SRV-1)) ? 8'd0 : dns_idx_q + 8'd1;
          rs_send_q <= 1'b1;
          err_q     <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dns_idx_o     = dns_idx_q;
  assign acc_o         = acc_q;
  assign val_o         = val_q;
  assign err_o         = err_q;
  assign hit_o         = hit_q;
  assign addr_o        = addr_q;
  assign rs_send_o     = rs_send_q;
  assign tx_pend_o     = tx_pend_q;
  assign tx_meta_ip_o  = tx_ip_q;
  assign tx_meta_udp_o = tx_udp_q;
  assign tx_meta_dns_o = tx_dns_q;

endmodule
